// File: rtl/perf_sample_ctrl.sv
// Perf-counter port arbiter: CSR accesses take priority; a periodic sampler scans a window of counters.
// Build option PERF_SAMPLE_CLEAR_EN: each scan read also clears the counter (read-then-clear).
//
// state  | meaning
// S_IDLE | waiting for a timer trigger with a non-empty window
// S_SCAN | issuing one counter read per cycle from idx_q up to last_q
module perf_sample_ctrl #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned IDX_W    = 5,
  parameter int unsigned PERIOD_W = 32,
  parameter int unsigned SEQ_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                csr_req_i,
  input  logic                csr_we_i,
  input  logic [IDX_W-1:0]    csr_addr_i,
  input  logic [XLEN-1:0]     csr_wdata_i,
  output logic                csr_rvalid_o,
  output logic [XLEN-1:0]     csr_rdata_o,
  output logic [IDX_W-1:0]    pc_addr_o,
  output logic                pc_we_o,
  output logic [XLEN-1:0]     pc_wdata_o,
  input  logic [XLEN-1:0]     pc_rdata_i,
  input  logic                sample_en_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [IDX_W-1:0]    first_idx_i,
  input  logic [IDX_W-1:0]    last_idx_i,
  output logic                smp_valid_o,
  input  logic                smp_ready_i,
  output logic [IDX_W-1:0]    smp_idx_o,
  output logic [XLEN-1:0]     smp_data_o,
  output logic [SEQ_W-1:0]    smp_seq_o,
  output logic                busy_o,
  output logic                overrun_o,
  input  logic                overrun_clr_i
);

  typedef enum logic {S_IDLE, S_SCAN} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, last_q;
  logic [SEQ_W-1:0]      seq_q;
  logic [PERIOD_W-1:0]   timer_q;
  logic                  active_q;
  logic                  timer_act, trigger, win_ok, start, issue, last_issue;

  assign timer_act  = sample_en_i && (period_i != '0);
  // active_q makes the first enabled cycle a reload, so the first trigger lands a full period later
  assign trigger    = timer_act && active_q && (timer_q == '0);
  assign win_ok     = (first_idx_i <= last_idx_i);
  assign start      = (state_q == S_IDLE) && trigger && win_ok;
  assign issue      = (state_q == S_SCAN) && !csr_req_i && (!smp_valid_o || smp_ready_i);
  assign last_issue = issue && (idx_q == last_q);
  assign busy_o     = (state_q == S_SCAN);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_q  <= '0;
      active_q <= 1'b0;
    end else begin
      active_q <= timer_act;
      if (!timer_act || !active_q || (timer_q == '0)) begin
        timer_q <= period_i - PERIOD_W'(1);
      end else begin
        timer_q <= timer_q - PERIOD_W'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_addr_o  = '0;
    pc_we_o    = 1'b0;
    pc_wdata_o = '0;
    case (state_q)
      S_IDLE: if (start) state_d = S_SCAN;
      S_SCAN: if (last_issue) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (csr_req_i) begin
      pc_addr_o  = csr_addr_i;
      pc_we_o    = csr_we_i;
      pc_wdata_o = csr_wdata_i;
    end else if (issue) begin
      pc_addr_o = idx_q;
`ifdef PERF_SAMPLE_CLEAR_EN
      pc_we_o   = 1'b1;
`else
      pc_we_o   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      last_q       <= '0;
      seq_q        <= '0;
      smp_valid_o  <= 1'b0;
      smp_idx_o    <= '0;
      smp_data_o   <= '0;
      smp_seq_o    <= '0;
      overrun_o    <= 1'b0;
      csr_rvalid_o <= 1'b0;
      csr_rdata_o  <= '0;
    end else begin
      state_q <= state_d;
      // window is latched at scan start; last index is compared before the increment, so 31 never wraps
      if (start) begin
        idx_q  <= first_idx_i;
        last_q <= last_idx_i;
      end else if (issue) begin
        idx_q <= idx_q + IDX_W'(1);
        if (last_issue) seq_q <= seq_q + SEQ_W'(1);
      end

      if (issue) begin
        smp_valid_o <= 1'b1;
        smp_idx_o   <= idx_q;
        smp_data_o  <= pc_rdata_i;
        smp_seq_o   <= seq_q;
      end else if (smp_ready_i) begin
        smp_valid_o <= 1'b0;
      end

      if ((state_q == S_SCAN) && trigger) begin
        overrun_o <= 1'b1;
      end else if (overrun_clr_i) begin
        overrun_o <= 1'b0;
      end

      csr_rvalid_o <= csr_req_i && !csr_we_i;
      if (csr_req_i && !csr_we_i) csr_rdata_o <= pc_rdata_i;
    end
  end

endmodule

// File: tb/tb_perf_sample_ctrl.sv
// Directed bench for perf_sample_ctrl with a behavioural 32-entry counter array on the port.
module tb_perf_sample_ctrl;
  localparam int XLEN = 32, IDX_W = 5, PERIOD_W = 32, SEQ_W = 16;
`ifdef PERF_SAMPLE_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic csr_req = 0, csr_we = 0;
  logic [IDX_W-1:0] csr_addr = '0;
  logic [XLEN-1:0] csr_wdata = '0;
  logic csr_rvalid;
  logic [XLEN-1:0] csr_rdata;
  logic [IDX_W-1:0] pc_addr;
  logic pc_we;
  logic [XLEN-1:0] pc_wdata, pc_rdata;
  logic sample_en = 0;
  logic [PERIOD_W-1:0] period = '0;
  logic [IDX_W-1:0] first_idx = '0, last_idx = '0;
  logic smp_valid, smp_ready = 1'b1;
  logic [IDX_W-1:0] smp_idx;
  logic [XLEN-1:0] smp_data;
  logic [SEQ_W-1:0] smp_seq;
  logic busy, overrun, overrun_clr = 0;

  perf_sample_ctrl #(.XLEN(XLEN), .IDX_W(IDX_W), .PERIOD_W(PERIOD_W), .SEQ_W(SEQ_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .csr_req_i(csr_req), .csr_we_i(csr_we), .csr_addr_i(csr_addr), .csr_wdata_i(csr_wdata),
    .csr_rvalid_o(csr_rvalid), .csr_rdata_o(csr_rdata),
    .pc_addr_o(pc_addr), .pc_we_o(pc_we), .pc_wdata_o(pc_wdata), .pc_rdata_i(pc_rdata),
    .sample_en_i(sample_en), .period_i(period), .first_idx_i(first_idx), .last_idx_i(last_idx),
    .smp_valid_o(smp_valid), .smp_ready_i(smp_ready), .smp_idx_o(smp_idx), .smp_data_o(smp_data),
    .smp_seq_o(smp_seq), .busy_o(busy), .overrun_o(overrun), .overrun_clr_i(overrun_clr)
  );

  always #5 clk = ~clk;

  logic [XLEN-1:0] mem [32];
  logic mem_init = 1'b1;
  assign pc_rdata = mem[pc_addr];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h1000 + i;
    end else if (pc_we) begin
      mem[pc_addr] <= pc_wdata;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [IDX_W-1:0] idx; logic [XLEN-1:0] data; logic [SEQ_W-1:0] seq; int cyc; } smp_t;
  smp_t sq[$];
  always @(negedge clk) begin
    if (!rst_i && smp_valid && smp_ready) sq.push_back('{smp_idx, smp_data, smp_seq, cyc});
  end

  typedef struct {
    logic req; logic we; logic [IDX_W-1:0] addr; logic [XLEN-1:0] wdata;
    logic [IDX_W-1:0] e_addr; logic e_we; logic [XLEN-1:0] e_wdata; logic e_rvalid; logic [XLEN-1:0] e_rdata;
  } vec_t;
  vec_t vecs [8];

  logic [XLEN-1:0] exp_mem [32];
  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input int max);
    int n = 0;
    while (!busy && n < max) begin tick(); n++; end
    check("wait_busy", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin tick(); n++; end
    check("wait_idle", {63'd0, busy}, 64'd0);
  endtask

  // pops n samples expected to be idx first..first+n-1 of epoch seq
  task automatic pop_samples(input int n, input int first, input int seq);
    smp_t s;
    for (int k = 0; k < n; k++) begin
      if (sq.size() == 0) begin
        check("smp_missing", 64'd0, 64'd1);
        return;
      end
      s = sq.pop_front();
      check("smp_idx", 64'(s.idx), 64'(first + k));
      check("smp_data", 64'(s.data), 64'(exp_mem[first + k]));
      check("smp_seq", 64'(s.seq), 64'(seq));
      if (CLR) exp_mem[first + k] = '0;
    end
  endtask

  initial begin
    int e;
    for (int i = 0; i < 32; i++) exp_mem[i] = 32'h1000 + i;
    //          req we addr  wdata         e_addr e_we e_wdata       rv  rdata
    vecs[0] = '{0, 0, 5'd3,  32'h0,        5'd0,  0, 32'h0,        0, 32'h0};
    vecs[1] = '{1, 0, 5'd7,  32'h0000_AAAA, 5'd7, 0, 32'h0000_AAAA, 1, 32'h1007};
    vecs[2] = '{1, 1, 5'd9,  32'hDEAD_BEEF, 5'd9, 1, 32'hDEAD_BEEF, 0, 32'h0};
    vecs[3] = '{1, 0, 5'd9,  32'h0,        5'd9,  0, 32'h0,        1, 32'hDEAD_BEEF};
    vecs[4] = '{1, 0, 5'd31, 32'h0,        5'd31, 0, 32'h0,        1, 32'h101F};
    vecs[5] = '{1, 1, 5'd0,  32'h1234_5678, 5'd0, 1, 32'h1234_5678, 0, 32'h0};
    vecs[6] = '{1, 0, 5'd0,  32'h0,        5'd0,  0, 32'h0,        1, 32'h1234_5678};
    vecs[7] = '{0, 1, 5'd12, 32'hFFFF_FFFF, 5'd0, 0, 32'h0,        0, 32'h0};

    repeat (3) tick();
    check("rst_busy", {63'd0, busy}, 0);
    check("rst_valid", {63'd0, smp_valid}, 0);
    check("rst_overrun", {63'd0, overrun}, 0);
    check("rst_rvalid", {63'd0, csr_rvalid}, 0);
    check("rst_pc_we", {63'd0, pc_we}, 0);
    rst_i = 0; mem_init = 0;
    tick();

    foreach (vecs[v]) begin
      csr_req = vecs[v].req; csr_we = vecs[v].we; csr_addr = vecs[v].addr; csr_wdata = vecs[v].wdata;
      #1;
      check("mux_addr", 64'(pc_addr), 64'(vecs[v].e_addr));
      check("mux_we", {63'd0, pc_we}, {63'd0, vecs[v].e_we});
      check("mux_wdata", 64'(pc_wdata), 64'(vecs[v].e_wdata));
      if (vecs[v].req && vecs[v].we) exp_mem[vecs[v].addr] = vecs[v].wdata;
      tick();
      check("csr_rvalid", {63'd0, csr_rvalid}, {63'd0, vecs[v].e_rvalid});
      if (vecs[v].e_rvalid) check("csr_rdata", 64'(csr_rdata), 64'(vecs[v].e_rdata));
    end
    csr_req = 0; csr_we = 0; csr_wdata = '0;

    // periodic scans 3..5, period 10
    period = 10; first_idx = 3; last_idx = 5; smp_ready = 1;
    sample_en = 1; e = cyc;
    for (int k = 0; k <= 25; k++) begin
      if (k == 10) check("t1_busy_pre", {63'd0, busy}, 0);
      if (k == 11) check("t1_busy_start", {63'd0, busy}, 1);
      tick();
    end
    sample_en = 0;
    check("t1_count", 64'(sq.size()), 64'd6);
    if (sq.size() == 6) begin
      for (int k = 0; k < 3; k++) begin
        check("t1_cyc_a", 64'(sq[k].cyc), 64'(e + 12 + k));
        check("t1_cyc_b", 64'(sq[k + 3].cyc), 64'(e + 22 + k));
      end
    end
    pop_samples(3, 3, 0);
    pop_samples(3, 3, 1);
    sq.delete();

    // CSR reads steal the port for two cycles mid-scan; enable dropped mid-scan
    first_idx = 0; last_idx = 4;
    sample_en = 1; e = cyc;
    for (int k = 0; k <= 20; k++) begin
      csr_req = (k == 12 || k == 13); csr_we = 0; csr_addr = 7;
      if (k == 12) sample_en = 0;
      #1;
      if (k == 12) check("t2_csr_wins", 64'(pc_addr), 64'd7);
      if (k == 13 || k == 14) begin
        check("t2_rvalid", {63'd0, csr_rvalid}, 1);
        check("t2_rdata", 64'(csr_rdata), 64'(exp_mem[7]));
      end
      if (k == 15) check("t2_rvalid_off", {63'd0, csr_rvalid}, 0);
      tick();
    end
    csr_req = 0;
    check("t2_count", 64'(sq.size()), 64'd5);
    pop_samples(5, 0, 2);
    sq.delete();

    // back-pressure: ready low for 5 cycles with a sample pending
    period = 3; first_idx = 8; last_idx = 10; smp_ready = 0;
    sample_en = 1;
    wait_busy(20);
    sample_en = 0;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("t3_valid", {63'd0, smp_valid}, 1);
      check("t3_idx", 64'(smp_idx), 64'd8);
      check("t3_data", 64'(smp_data), 64'(exp_mem[8]));
      tick();
    end
    smp_ready = 1;
    repeat (5) tick();
    check("t3_count", 64'(sq.size()), 64'd3);
    pop_samples(3, 8, 3);
    sq.delete();

    // full window with period 2: overrun, then clear
    period = 2; first_idx = 0; last_idx = 31;
    sample_en = 1;
    wait_busy(10);
    repeat (3) tick();
    check("t4_overrun", {63'd0, overrun}, 1);
    sample_en = 0;
    wait_idle(60);
    overrun_clr = 1;
    tick();
    overrun_clr = 0;
    check("t4_overrun_clr", {63'd0, overrun}, 0);
    tick();
    check("t4_count", 64'(sq.size()), 64'd32);
    if (sq.size() == 32) check("t4_last_idx", 64'(sq[31].idx), 64'd31);
    pop_samples(32, 0, 4);
    sq.delete();

    // empty window is ignored
    period = 2; first_idx = 6; last_idx = 2;
    sample_en = 1;
    begin
      int busy_cycles = 0;
      for (int k = 0; k < 12; k++) begin
        if (busy) busy_cycles++;
        tick();
      end
      check("t5_busy_cycles", 64'(busy_cycles), 64'd0);
    end
    sample_en = 0;
    tick();
    check("t5_samples", 64'(sq.size()), 64'd0);
    check("t5_overrun", {63'd0, overrun}, 0);

    // read-then-clear option on counter 4
    csr_req = 1; csr_we = 1; csr_addr = 4; csr_wdata = 32'h55;
    exp_mem[4] = 32'h55;
    tick();
    csr_req = 0; csr_we = 0; csr_wdata = '0;
    first_idx = 4; last_idx = 4; period = 2;
    sample_en = 1;
    wait_busy(10);
    sample_en = 0;
    check("t6_addr", 64'(pc_addr), 64'd4);
    check("t6_we", {63'd0, pc_we}, {63'd0, CLR});
    check("t6_wdata", 64'(pc_wdata), 64'd0);
    repeat (3) tick();
    check("t6_count", 64'(sq.size()), 64'd1);
    pop_samples(1, 4, 5);
    sq.delete();
    csr_req = 1; csr_we = 0; csr_addr = 4;
    tick();
    csr_req = 0;
    check("t6_rb_valid", {63'd0, csr_rvalid}, 1);
    check("t6_rb_data", 64'(csr_rdata), 64'(exp_mem[4]));

    // reset mid-scan drops the pending sample and zeroes the epoch
    period = 2; first_idx = 0; last_idx = 3; smp_ready = 0;
    sample_en = 1;
    wait_busy(10);
    sample_en = 0;
    if (CLR) exp_mem[0] = '0;
    tick();
    check("t7_pending", {63'd0, smp_valid}, 1);
    rst_i = 1;
    tick();
    rst_i = 0;
    check("t7_busy", {63'd0, busy}, 0);
    check("t7_valid", {63'd0, smp_valid}, 0);
    check("t7_seq", 64'(smp_seq), 64'd0);
    sq.delete();
    smp_ready = 1; first_idx = 2; last_idx = 3;
    sample_en = 1;
    wait_busy(10);
    sample_en = 0;
    repeat (4) tick();
    check("t7_count", 64'(sq.size()), 64'd2);
    pop_samples(2, 2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
